// File: rtl/ifetch_line_buffer.sv
// Line-buffered instruction fetch: one AXI INCR burst per aligned line, 32-bit words to decode.
// Build option IFETCH_ZERO_HALT_EN: accepting a zero instruction halts fetch until reset.
module ifetch_line_buffer #(
    parameter int                  ID_WIDTH   = 13,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  LINE_BEATS = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  halted
);
    localparam int BYTE_W     = $clog2(DATA_WIDTH / 8);
    localparam int LINE_BYTES = LINE_BEATS * DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {ADDR_WIDTH{1'b1}} << 2;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_SERVE, S_DRAIN, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  tag_valid_q, tag_valid_d;
    logic                  err_q, err_d;
    logic                  drain_pend_q, drain_pend_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
`ifdef IFETCH_ZERO_HALT_EN
    logic                  halted_q, halted_d;
`endif

    logic [DATA_WIDTH-1:0] line_mem [1 << BEAT_W];
    logic [DATA_WIDTH-1:0] cur_beat;
    logic [31:0]           inst_word;
    logic                  hit;

    assign cur_beat  = line_mem[BEAT_W'(pc_q[OFF_W-1:0] >> BYTE_W)];
    assign inst_word = 32'(cur_beat >> {pc_q[BYTE_W-1:0], 3'b000});
    assign hit       = tag_valid_q && ((pc_q & LINE_MASK) == tag_q);

    assign inst_valid = (state_q == S_SERVE) && hit && !redirect_valid;
    assign inst       = inst_valid ? inst_word : 32'h0;
    assign inst_pc    = inst_valid ? pc_q : '0;
    assign inst_fault = inst_valid && err_q;

    assign m_axi_arid    = AXI_ID;
    assign m_axi_arlen   = 8'(LINE_BEATS - 1);
    assign m_axi_arsize  = 3'(BYTE_W);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == S_REQ);
    assign m_axi_araddr  = m_axi_arvalid ? araddr_q : '0;
    assign m_axi_rready  = (state_q == S_FILL) || (state_q == S_DRAIN);

`ifdef IFETCH_ZERO_HALT_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tag_d        = tag_q;
        araddr_d     = araddr_q;
        tag_valid_d  = tag_valid_q;
        err_d        = err_q;
        drain_pend_d = drain_pend_q;
        beat_d       = beat_q;
`ifdef IFETCH_ZERO_HALT_EN
        halted_d     = halted_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // An issued AR is never withdrawn; a redirect only decides whether its data is kept.
                if (m_axi_arready) begin
                    state_d      = (drain_pend_q || redirect_valid) ? S_DRAIN : S_FILL;
                    beat_d       = '0;
                    err_d        = 1'b0;
                    tag_valid_d  = 1'b0;
                    drain_pend_d = 1'b0;
                end else if (redirect_valid) begin
                    drain_pend_d = 1'b1;
                end
            end
            S_FILL: begin
                if (m_axi_rvalid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if ((m_axi_rresp & 2'b10) != 2'b00) err_d = 1'b1;
                    if (m_axi_rlast) begin
                        tag_d       = araddr_q;
                        tag_valid_d = 1'b1;
                        state_d     = S_SERVE;
                    end
                end
                if (redirect_valid) begin
                    tag_valid_d = 1'b0;
                    state_d     = (m_axi_rvalid && m_axi_rlast) ? S_REQ : S_DRAIN;
                end
            end
            S_SERVE: begin
                if (!redirect_valid) begin
                    if (!hit) begin
                        state_d = S_REQ;
                    end else if (inst_ready) begin
                        pc_d = pc_q + ADDR_WIDTH'(4);
`ifdef IFETCH_ZERO_HALT_EN
                        if (inst_word == 32'h0) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
`endif
                    end
                end
            end
            S_DRAIN: if (m_axi_rvalid && m_axi_rlast) state_d = S_REQ;
            default: ;
        endcase

        if (redirect_valid && state_q != S_HALT) begin
            pc_d = redirect_pc & WORD_MASK;
            if (state_q == S_IDLE) state_d = S_SERVE;
        end

        // Address is captured once on entry so it stays stable for the whole AR handshake.
        if (state_d == S_REQ && state_q != S_REQ) araddr_d = pc_d & LINE_MASK;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_FILL && m_axi_rvalid) line_mem[beat_q] <= m_axi_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= entry & WORD_MASK;
            tag_q        <= '0;
            araddr_q     <= '0;
            tag_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            drain_pend_q <= 1'b0;
            beat_q       <= '0;
`ifdef IFETCH_ZERO_HALT_EN
            halted_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tag_q        <= tag_d;
            araddr_q     <= araddr_d;
            tag_valid_q  <= tag_valid_d;
            err_q        <= err_d;
            drain_pend_q <= drain_pend_d;
            beat_q       <= beat_d;
`ifdef IFETCH_ZERO_HALT_EN
            halted_q     <= halted_d;
`endif
        end
    end
endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Bench for ifetch_line_buffer: AXI memory responder plus a sequential-PC instruction stream model.
module tb_ifetch_line_buffer;
    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int LB  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [AW-1:0]  entry;
    logic           inst_valid, inst_ready, inst_fault;
    logic [31:0]    inst;
    logic [AW-1:0]  inst_pc;
    logic           redirect_valid;
    logic [AW-1:0]  redirect_pc;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize;
    logic [1:0]     m_axi_arburst;
    logic           m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]  m_axi_rdata;
    logic [1:0]     m_axi_rresp;
    logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic           halted;

    ifetch_line_buffer dut (
        .clk(clk), .reset(reset), .entry(entry),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .halted(halted)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    int          n_fault = 0;
    logic [63:0] exp_pc = 64'h0;
    logic [63:0] last_pc = 64'h0;
    logic [63:0] err_line = 64'hFFFF_FFFF_FFFF_0000;
    logic [63:0] ar_log [$];
    logic [63:0] burst_addr = 64'h0;
    int          beats_done = 0;
    bit          burst_active = 1'b0;
    int          arready_pct = 100;
    int          rvalid_pct = 100;
    bit          check_ar = 1'b0;

    // Memory image: word at 0x1000 is 0x13, incrementing by one per word.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
`ifdef IFETCH_ZERO_HALT_EN
        if (a == 64'h1008) return 32'h0;
`endif
        return 32'h13 + 32'((a - 64'h1000) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // AXI read responder: one burst at a time, beat 5 of err_line answers SLVERR.
    initial begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                burst_active = 1'b0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                continue;
            end
            m_axi_arready = !burst_active && ($urandom_range(99) < arready_pct);
            m_axi_rvalid  = burst_active && ($urandom_range(99) < rvalid_pct);
            m_axi_rlast   = burst_active && (beats_done == LB - 1);
            m_axi_rdata   = {mem_word(burst_addr + 64'(8 * beats_done + 4)),
                             mem_word(burst_addr + 64'(8 * beats_done))};
            m_axi_rresp   = (burst_active && burst_addr == err_line && beats_done == 5) ? 2'b10 : 2'b00;
            #1;
            if (m_axi_arvalid && m_axi_arready) begin
                chk("arlen", 64'(m_axi_arlen), 64'd7);
                chk("arsize", 64'(m_axi_arsize), 64'd3);
                chk("arburst", 64'(m_axi_arburst), 64'd1);
                chk("arid", 64'(m_axi_arid), 64'd0);
                ar_log.push_back(m_axi_araddr);
                burst_addr   = m_axi_araddr;
                beats_done   = 0;
                burst_active = 1'b1;
            end else if (m_axi_rvalid) begin
                chk("rready", 64'(m_axi_rready), 64'd1);
                if (m_axi_rready) begin
                    if (beats_done == LB - 1) burst_active = 1'b0;
                    beats_done++;
                end
            end
        end
    end

    // One clock of decode-side stimulus, checked against the expected in-order PC stream.
    task automatic cyc(input logic rdy, input logic redir, input logic [63:0] rpc);
        @(negedge clk);
        inst_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
        #3;
        if (check_ar && m_axi_arvalid) chk("araddr", m_axi_araddr, exp_pc & ~64'h3F);
        if (redir) begin
            chk("valid_in_redirect", 64'(inst_valid), 64'd0);
            exp_pc = rpc & ~64'h3;
        end else if (inst_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", 64'(inst), 64'(mem_word(exp_pc)));
            chk("inst_fault", 64'(inst_fault), 64'((exp_pc & ~64'h3F) == err_line));
            if (rdy) begin
                $display("accept pc=%h inst=%h fault=%0d", inst_pc, inst, inst_fault);
                last_pc = inst_pc;
                if (inst_fault) n_fault++;
                exp_pc += 64'd4;
                n_acc++;
            end
        end
    endtask

    task automatic run_until(input int n, input int pct, input int budget);
        int start = n_acc;
        int c = 0;
        while (n_acc - start < n && c < budget) begin
            cyc($urandom_range(99) < pct, 1'b0, 64'h0);
            c++;
        end
        chk("progress", 64'(n_acc - start), 64'(n));
    endtask

    initial begin
        int c;
        int n_ar;
        reset = 1'b1; entry = 64'h1003; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_araddr", m_axi_araddr, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd7);
        chk("rst_arsize", 64'(m_axi_arsize), 64'd3);
        @(negedge clk);
        reset = 1'b0;
        exp_pc = 64'h1000;
        check_ar = 1'b1;

`ifdef IFETCH_ZERO_HALT_EN
        run_until(3, 100, 200);
        cyc(1'b0, 1'b0, 64'h0);
        chk("halted", 64'(halted), 64'd1);
        n_ar = ar_log.size();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, i == 5, 64'h3000);
            chk("halt_no_inst", 64'(inst_valid), 64'd0);
            chk("halt_no_ar", 64'(m_axi_arvalid), 64'd0);
        end
        chk("halt_ar_count", 64'(ar_log.size()), 64'(n_ar));
        chk("halt_sticky", 64'(halted), 64'd1);
`else
        // Cold start and first line crossing.
        run_until(16, 100, 200);
        repeat (4) cyc(1'b0, 1'b0, 64'h0);
        chk("ar_first", (ar_log.size() >= 1) ? ar_log[0] : 64'hDEAD, 64'h1000);
        chk("ar_cross", (ar_log.size() >= 2) ? ar_log[1] : 64'hDEAD, 64'h1040);

        // Decode back-pressure, then AR back-pressure at the next line.
        repeat (10) cyc(1'b0, 1'b0, 64'h0);
        arready_pct = 0;
        run_until(16, 100, 200);
        repeat (10) cyc(1'b1, 1'b0, 64'h0);
        chk("arvalid_held", 64'(m_axi_arvalid), 64'd1);

        // Redirect during the fill of 0x1080.
        err_line = 64'h2040;
        arready_pct = 100;
        check_ar = 1'b0;
        c = 0;
        while (!(burst_active && beats_done >= 3) && c < 100) begin
            cyc(1'b1, 1'b0, 64'h0);
            c++;
        end
        chk("fill_reached", 64'(c < 100), 64'd1);
        cyc(1'b0, 1'b1, 64'h2004);
        run_until(1, 100, 200);
        chk("redirect_first_pc", last_pc, 64'h2004);
        chk("redirect_araddr", (ar_log.size() >= 1) ? ar_log[$] : 64'hDEAD, 64'h2000);

        // Error line 0x2040 surrounded by clean lines, with random handshakes.
        check_ar = 1'b1;
        arready_pct = 70;
        rvalid_pct = 70;
        n_fault = 0;
        run_until(60, 60, 3000);
        chk("fault_count", 64'(n_fault), 64'd16);

        // Random redirects across the whole flow.
        check_ar = 1'b0;
        c = n_acc;
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(99) < 70, $urandom_range(99) < 3,
                64'h1000 + 64'($urandom_range(0, 16383)));
        end
        chk("random_progress", 64'(n_acc - c > 50), 64'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
